rr_decode_arbiter: RTL

- Round-robin arbiter sharing one 16-way decoded resource (one-hot select bus) among 16 requesters.
- Registers a 4-bit winner index and drives the matching one-hot select, bit i high for index i.
- Holds each grant until the owner releases it or withdraws its request.
- Sits between requester blocks and the 4-to-16 one-hot select path feeding the shared resource.

---
 rtl/rr_decode_arbiter_pkg.sv | 19 +
 rtl/rr_decode_arbiter_if.sv | 23 ++
 rtl/rr_decode_arbiter_prio_pick.sv | 35 +++
 rtl/rr_decode_arbiter.sv | 111 +++++++++++
 4 files changed

// File: rtl/rr_decode_arbiter_pkg.sv
// Shared types and helpers for the round-robin decode arbiter.
// State encoding, requester/index sizing and the MSB-first one-hot decode.
package rr_decode_arbiter_pkg;

  localparam int N_REQ = 16;
  localparam int IDX_W = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // Bit 0 of the returned vector is the MSB, so idx 0 gives 16'h8000.
  function automatic logic [0:N_REQ-1] onehot_dec(input logic [IDX_W-1:0] idx);
    onehot_dec      = '0;
    onehot_dec[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/rr_decode_arbiter_if.sv
// Requester-side bus of the arbiter.
// The master modport is the requester side and the slave modport is the arbiter.
interface rr_decode_arbiter_if import rr_decode_arbiter_pkg::*; ();

  logic [0:N_REQ-1] req;
  logic             release_i;
  logic             gnt_valid;
  logic [0:IDX_W-1] gnt_idx;
  logic [0:N_REQ-1] gnt_onehot;
  logic             busy;
  logic             timeout_o;

  modport master (
    output req, release_i,
    input  gnt_valid, gnt_idx, gnt_onehot, busy, timeout_o
  );

  modport slave (
    input  req, release_i,
    output gnt_valid, gnt_idx, gnt_onehot, busy, timeout_o
  );

endinterface

// File: rtl/rr_decode_arbiter_prio_pick.sv
// Combinational round-robin pick: rotate req by ptr, find the first set bit, unrotate.
// o_any flags that at least one request is present.
module rr_prio_pick
  import rr_decode_arbiter_pkg::*;
(
  input  logic [0:N_REQ-1] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [IDX_W-1:0] o_winner,
  output logic             o_any
);

  logic [0:N_REQ-1] w_rot;
  logic [IDX_W-1:0] w_off;
  logic             w_found;

  // w_rot[0] is requester ptr, so the first set bit is the next in turn.
  always_comb begin
    w_rot   = '0;
    w_off   = '0;
    w_found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      w_rot[i] = i_req[i_ptr + IDX_W'(i)];
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (w_rot[i] && !w_found) begin
        w_off   = IDX_W'(i);
        w_found = 1'b1;
      end
    end
  end

  assign o_any    = |w_rot;
  assign o_winner = i_ptr + w_off;

endmodule

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter for a 16-way decoded resource; grant held until release or drop.
// Optional forced release after MAX_HOLD cycles when RR_ARB_TIMEOUT_EN is defined.
module rr_decode_arbiter
  import rr_decode_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  rr_decode_arbiter_if.slave  bus
);

  if (MAX_HOLD < 1) begin : g_bad_hold
    $error("rr_decode_arbiter: MAX_HOLD must be at least 1");
  end

  state_e           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_ptr, w_ptr_nxt;
  logic [IDX_W-1:0] r_gnt_idx, w_gnt_idx_nxt;
  logic [0:N_REQ-1] r_gnt_onehot, w_gnt_onehot_nxt;
  logic [IDX_W-1:0] w_winner;
  logic             w_any;
  logic             w_exit;

`ifdef RR_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  logic [CNT_W-1:0] r_hold_cnt, w_hold_cnt_nxt;
  logic             r_timeout, w_timeout_nxt;
`endif

  rr_prio_pick u_pick (
    .i_req    (bus.req),
    .i_ptr    (r_ptr),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  always_comb begin
    w_state_nxt      = r_state;
    w_ptr_nxt        = r_ptr;
    w_gnt_idx_nxt    = r_gnt_idx;
    w_gnt_onehot_nxt = r_gnt_onehot;
    w_exit           = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
    w_hold_cnt_nxt   = r_hold_cnt;
    w_timeout_nxt    = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nxt      = ST_GRANT;
          w_gnt_idx_nxt    = w_winner;
          w_gnt_onehot_nxt = onehot_dec(w_winner);
`ifdef RR_ARB_TIMEOUT_EN
          w_hold_cnt_nxt   = '0;
`endif
        end
      end
      ST_GRANT: begin
        // Release or withdrawal wins over a coincident timeout.
        w_exit = bus.release_i || !bus.req[r_gnt_idx];
`ifdef RR_ARB_TIMEOUT_EN
        w_hold_cnt_nxt = r_hold_cnt + CNT_W'(1);
        if (!w_exit && r_hold_cnt == CNT_W'(MAX_HOLD - 1)) begin
          w_exit        = 1'b1;
          w_timeout_nxt = 1'b1;
        end
`endif
        if (w_exit) begin
          w_state_nxt      = ST_IDLE;
          w_gnt_onehot_nxt = '0;
          w_ptr_nxt        = r_gnt_idx + IDX_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_ptr        <= '0;
      r_gnt_idx    <= '0;
      r_gnt_onehot <= '0;
`ifdef RR_ARB_TIMEOUT_EN
      r_hold_cnt   <= '0;
      r_timeout    <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_ptr        <= w_ptr_nxt;
      r_gnt_idx    <= w_gnt_idx_nxt;
      r_gnt_onehot <= w_gnt_onehot_nxt;
`ifdef RR_ARB_TIMEOUT_EN
      r_hold_cnt   <= w_hold_cnt_nxt;
      r_timeout    <= w_timeout_nxt;
`endif
    end
  end

  assign bus.gnt_valid  = (r_state == ST_GRANT);
  assign bus.busy       = (r_state == ST_GRANT);
  assign bus.gnt_idx    = r_gnt_idx;
  assign bus.gnt_onehot = r_gnt_onehot;
`ifdef RR_ARB_TIMEOUT_EN
  assign bus.timeout_o  = r_timeout;
`else
  assign bus.timeout_o  = 1'b0;
`endif

endmodule
